// File: rtl/refresh_scheduler_mb_pkg.sv
// Shared types and width helpers for the multi-bank refresh scheduler.
package refresh_pkg;

  typedef enum logic {IDLE, REQ} ref_state_t;

  function automatic int unsigned bank_w(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

  function automatic int unsigned pend_w(input int unsigned m);
    return int'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/refresh_scheduler_mb_if.sv
// Refresh request/ack handshake between the scheduler and the refresh engine.
interface refresh_scheduler_mb_if
  import refresh_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4
);
  localparam int unsigned BANK_W = bank_w(NUM_BANKS);

  logic              ref_req;
  logic [BANK_W-1:0] ref_bank;
  logic              ref_urgent;
  logic              ref_ack;

  modport master (output ref_req, ref_bank, ref_urgent, input ref_ack);
  modport slave  (input ref_req, ref_bank, ref_urgent, output ref_ack);
endinterface

// File: rtl/refresh_scheduler_mb_bank.sv
// Per-bank retention timer with pending-refresh counter and sticky overflow.
module bank_refresh_timer
  import refresh_pkg::*;
#(
  parameter int unsigned CYCLES       = 5000,
  parameter int unsigned MAX_POSTPONE = 3,
  parameter int unsigned RESET_PHASE  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic disable_ref,
  input  logic ack_this,
  output logic pending_nz,
  output logic urgent,
  output logic overflow
);
  localparam int unsigned CNT_W  = $clog2(CYCLES);
  localparam int unsigned PEND_W = pend_w(MAX_POSTPONE);

  logic [CNT_W-1:0]  timer;
  logic [PEND_W-1:0] pending, pend_next;
  logic              tick, ovf_set;

  assign tick = !disable_ref && (timer == CNT_W'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer <= CNT_W'(RESET_PHASE);
    else if (!disable_ref)
      timer <= tick ? '0 : timer + CNT_W'(1);
  end

  // A coincident tick and ack cancel; a tick at the limit is lost and flagged.
  always_comb begin
    pend_next = pending;
    ovf_set   = 1'b0;
    if (tick && !ack_this) begin
      if (pending == PEND_W'(MAX_POSTPONE))
        ovf_set = 1'b1;
      else
        pend_next = pending + PEND_W'(1);
    end else if (!tick && ack_this && (pending != '0)) begin
      pend_next = pending - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      pending_nz <= 1'b0;
      urgent     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pending    <= pend_next;
      pending_nz <= (pend_next != '0);
      urgent     <= (pend_next == PEND_W'(MAX_POSTPONE));
      if (ovf_set)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/refresh_scheduler_mb.sv
// Multi-bank refresh scheduler: per-bank timers, urgent/round-robin arbiter, req/ack FSM.
module refresh_scheduler_mb
  import refresh_pkg::*;
#(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned CYCLES       = 5000,
  parameter int unsigned MAX_POSTPONE = 3,
  parameter int unsigned STAGGER      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disable_ref,
  input  logic                   busy,
  refresh_scheduler_mb_if.master bus,
  output logic                   pending_any,
  output logic [NUM_BANKS-1:0]   overflow
);
  localparam int unsigned BANK_W = bank_w(NUM_BANKS);

  ref_state_t           state;
  logic [BANK_W-1:0]    ptr, cand_bank;
  logic                 cand_valid, cand_urgent;
  logic [NUM_BANKS-1:0] nz, urg, ack_vec;
  int unsigned          j;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign ack_vec[g] = (state == REQ) && bus.ref_ack && (bus.ref_bank == BANK_W'(g));

    bank_refresh_timer #(
      .CYCLES      (CYCLES),
      .MAX_POSTPONE(MAX_POSTPONE),
      .RESET_PHASE ((STAGGER != 0) ? g * (CYCLES / NUM_BANKS) : 0)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .disable_ref(disable_ref),
      .ack_this   (ack_vec[g]),
      .pending_nz (nz[g]),
      .urgent     (urg[g]),
      .overflow   (overflow[g])
    );
  end

  assign pending_any = |nz;

  // Descending scans so the last hit is the nearest round-robin / lowest urgent bank.
  always_comb begin
    cand_valid  = 1'b0;
    cand_urgent = 1'b0;
    cand_bank   = '0;
    j           = 0;
    for (int unsigned k = NUM_BANKS; k > 0; k--) begin
      j = 32'(ptr) + k - 1;
      if (j >= NUM_BANKS)
        j = j - NUM_BANKS;
      if (nz[BANK_W'(j)]) begin
        cand_valid = 1'b1;
        cand_bank  = BANK_W'(j);
      end
    end
    for (int unsigned k = NUM_BANKS; k > 0; k--) begin
      if (urg[BANK_W'(k - 1)]) begin
        cand_valid  = 1'b1;
        cand_urgent = 1'b1;
        cand_bank   = BANK_W'(k - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.ref_req    <= 1'b0;
      bus.ref_bank   <= '0;
      bus.ref_urgent <= 1'b0;
      ptr            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_valid && !disable_ref && (!busy || cand_urgent)) begin
            state          <= REQ;
            bus.ref_req    <= 1'b1;
            bus.ref_bank   <= cand_bank;
            bus.ref_urgent <= cand_urgent;
          end
        end
        REQ: begin
          if (bus.ref_ack) begin
            state          <= IDLE;
            bus.ref_req    <= 1'b0;
            bus.ref_urgent <= 1'b0;
            ptr <= (bus.ref_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : bus.ref_bank + BANK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_refresh_scheduler_mb.sv
// Bench: two schedulers (staggered / unstaggered) checked every cycle against a behavioural model.
module tb_refresh_scheduler_mb;
  localparam int N = 4;
  localparam int C = 16;
  localparam int M = 3;

  logic clk = 1'b0;
  logic rst, disable_ref, busy;
  logic pa0, pa1;
  logic [N-1:0] ov0, ov1;

  refresh_scheduler_mb_if #(.NUM_BANKS(N)) bus0 ();
  refresh_scheduler_mb_if #(.NUM_BANKS(N)) bus1 ();

  refresh_scheduler_mb #(.NUM_BANKS(N), .CYCLES(C), .MAX_POSTPONE(M), .STAGGER(1)) dut0 (
    .clk(clk), .rst(rst), .disable_ref(disable_ref), .busy(busy),
    .bus(bus0), .pending_any(pa0), .overflow(ov0));

  refresh_scheduler_mb #(.NUM_BANKS(N), .CYCLES(C), .MAX_POSTPONE(M), .STAGGER(0)) dut1 (
    .clk(clk), .rst(rst), .disable_ref(disable_ref), .busy(busy),
    .bus(bus1), .pending_any(pa1), .overflow(ov1));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0: inputs set by caller, 1: ack every request, 2: random

  // Behavioural model: obligations per bank, outstanding request, round-robin start.
  int pend [2][N];
  bit ovf  [2][N];
  bit mreq [2];
  int mbank[2];
  bit murg [2];
  int mptr [2];
  int en_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int phase(input int d, input int i);
    return (d == 0) ? i * (C / N) : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        pend[d][i] = 0;
        ovf[d][i]  = 0;
      end
      mreq[d] = 0; mbank[d] = 0; murg[d] = 0; mptr[d] = 0;
    end
    en_cnt = 0;
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic ackv;
      int   ab, cand;
      bit   curg, tick;
      ackv = (d == 0) ? bus0.ref_ack : bus1.ref_ack;
      ab = (mreq[d] && ackv) ? mbank[d] : -1;
      cand = -1;
      curg = 0;
      for (int k = 0; k < N; k++)
        if (cand < 0 && pend[d][k] == M) begin cand = k; curg = 1; end
      for (int k = 0; k < N; k++)
        if (cand < 0 && pend[d][(mptr[d] + k) % N] != 0) cand = (mptr[d] + k) % N;
      if (mreq[d]) begin
        if (ackv) begin
          mreq[d] = 0;
          mptr[d] = (mbank[d] + 1) % N;
        end
      end else if (cand >= 0 && !disable_ref && (!busy || curg)) begin
        mreq[d] = 1; mbank[d] = cand; murg[d] = curg;
      end
      for (int i = 0; i < N; i++) begin
        tick = !disable_ref && ((phase(d, i) + en_cnt) % C == C - 1);
        if (tick && ab != i) begin
          if (pend[d][i] == M) ovf[d][i] = 1;
          else pend[d][i]++;
        end else if (!tick && ab == i) begin
          pend[d][i]--;
        end
      end
    end
    if (!disable_ref) en_cnt++;
  endtask

  task automatic cmp(input int d, input logic req, input logic [1:0] bank, input logic urg,
                     input logic pa, input logic [N-1:0] ov);
    logic [N-1:0] eov;
    bit epa;
    epa = 0;
    for (int i = 0; i < N; i++) begin
      eov[i] = ovf[d][i];
      if (pend[d][i] != 0) epa = 1;
    end
    chk($sformatf("d%0d_ref_req", d), req, mreq[d]);
    if (mreq[d]) begin
      chk($sformatf("d%0d_ref_bank", d), bank, mbank[d]);
      chk($sformatf("d%0d_ref_urgent", d), urg, murg[d]);
    end
    chk($sformatf("d%0d_pending_any", d), pa, epa);
    chk($sformatf("d%0d_overflow", d), ov, eov);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    cmp(0, bus0.ref_req, bus0.ref_bank, bus0.ref_urgent, pa0, ov0);
    cmp(1, bus1.ref_req, bus1.ref_bank, bus1.ref_urgent, pa1, ov1);
    if (mode == 1) begin
      bus0.ref_ack = mreq[0];
      bus1.ref_ack = mreq[1];
    end else if (mode == 2) begin
      busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) disable_ref = !disable_ref;
      bus0.ref_ack = mreq[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus1.ref_ack = mreq[1] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called in the low phase after a negedge; reset must act without a clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_req0", bus0.ref_req, 1'b0);
    chk("rst_async_req1", bus1.ref_req, 1'b0);
    chk("rst_ovf0", ov0, '0);
    chk("rst_ovf1", ov1, '0);
    chk("rst_pa0", pa0, 1'b0);
    model_reset();
    busy = 1'b0; disable_ref = 1'b0; bus0.ref_ack = 1'b0; bus1.ref_ack = 1'b0;
    mode = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit did_rst;
    rst = 1'b1; busy = 1'b0; disable_ref = 1'b0;
    bus0.ref_ack = 1'b0; bus1.ref_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_req", bus0.ref_req, 1'b0);
    chk("reset_bank", bus0.ref_bank, 2'd0);
    chk("reset_urgent", bus0.ref_urgent, 1'b0);
    chk("reset_pending_any", pa0, 1'b0);
    chk("reset_overflow", ov1, 4'h0);
    rst = 1'b0;

    // Staggered banks served 3,2,1,0 with immediate acks.
    mode = 1;
    steps(4);
    chk("s2_req_not_yet", bus0.ref_req, 1'b0);
    step();
    chk("s2_first_req", bus0.ref_req, 1'b1);
    chk("s2_first_bank", bus0.ref_bank, 2'd3);
    chk("s2_first_urgent", bus0.ref_urgent, 1'b0);
    steps(4);
    chk("s2_second_req", bus0.ref_req, 1'b1);
    chk("s2_second_bank", bus0.ref_bank, 2'd2);
    steps(31);
    chk("s2_no_overflow", ov0, 4'h0);
    apply_reset();

    // Busy with no acks: urgent request at the postpone limit, then overflow.
    busy = 1'b1;
    steps(48);
    chk("s3_pre_urgent", bus1.ref_req, 1'b0);
    step();
    chk("s3_urgent_req", bus1.ref_req, 1'b1);
    chk("s3_urgent_bank", bus1.ref_bank, 2'd0);
    chk("s3_urgent_flag", bus1.ref_urgent, 1'b1);
    steps(15);
    chk("s4_overflow_all", ov1, 4'hF);
    chk("s3_req_held", bus1.ref_req, 1'b1);
    steps(6);
    chk("s4_overflow_sticky", ov1, 4'hF);
    bus1.ref_ack = 1'b1;
    step();
    bus1.ref_ack = 1'b0;
    chk("s3_req_dropped", bus1.ref_req, 1'b0);
    steps(3);
    chk("s6_req_before_rst", bus0.ref_req, 1'b1);
    apply_reset();

    // Ack lands on the same edge as bank 0's tick at its limit: no loss for bank 0.
    busy = 1'b1;
    steps(63);
    bus0.ref_ack = 1'b1;
    bus1.ref_ack = 1'b1;
    step();
    bus0.ref_ack = 1'b0;
    bus1.ref_ack = 1'b0;
    chk("s6_tick_ack_ovf", ov1, 4'hE);
    chk("s6_tick_ack_req", bus1.ref_req, 1'b0);
    steps(3);
    apply_reset();

    // Timers frozen for 40 cycles delay bank 3's first request by 40.
    mode = 1;
    steps(2);
    disable_ref = 1'b1;
    steps(40);
    disable_ref = 1'b0;
    steps(2);
    chk("s5_req_not_yet", bus0.ref_req, 1'b0);
    step();
    chk("s5_delayed_req", bus0.ref_req, 1'b1);
    chk("s5_delayed_bank", bus0.ref_bank, 2'd3);
    steps(15);
    apply_reset();

    // Random traffic with one reset taken mid-handshake.
    mode = 2;
    did_rst = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!did_rst && n >= 1500 && mreq[0]) begin
        apply_reset();
        did_rst = 1;
        mode = 2;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
